// File: rtl/ov7670_src_pkg.sv
// Shared types and constants for the synthetic OV7670 DVP source.
//   frameState_e  : vertical frame state (idle, sync, back porch, active, front porch)
//   patternKind_e : test pattern selection, encoded as on the patternSel port
//   BAR_*         : RGB565 colours of the eight colour bars, left to right
package ov7670_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } frameState_e;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_GRADIENT,
        PAT_CHECKER,
        PAT_SOLID
    } patternKind_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] barColour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 pixel value for one active-video coordinate.
//   x, y    : pixel coordinate within active video (low 8 bits are enough)
//   barIdx  : colour bar index 0..7, produced by the caller's bar counter
//   pattern : latched pattern selection
//   pixel   : RGB565 value
module ov7670_pattern_gen
    import ov7670_src_pkg::*;
(
    input  logic [7:0]   x,
    input  logic [7:0]   y,
    input  logic [2:0]   barIdx,
    input  patternKind_e pattern,
    output logic [15:0]  pixel
);

    always_comb begin
        pixel = 16'h0000;
        case (pattern)
            PAT_BARS:     pixel = barColour(barIdx);
            PAT_GRADIENT: pixel = {x, y};
            PAT_CHECKER:  pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            PAT_SOLID:    pixel = 16'hFFFF;
            default:      pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov7670_pattern_source.sv
// Synthetic OV7670 camera: drives a DVP bus (pclk/vsync/href/data) carrying
// RGB565 test patterns, two bytes per pixel, high byte first.
//   clk           : system clock, all logic on posedge
//   reset         : asynchronous, active-high
//   enable        : run request, sampled only at frame boundaries
//   patternSel    : 0 bars, 1 gradient, 2 checkerboard, 3 solid white
//   pclk          : clk divided by PCLK_DIV
//   vsync, href   : frame / line qualifiers
//   data          : byte bus, 0 whenever href is low
//   frameDone     : one-clk strobe after the last active byte of a frame
//   frameChecksum : byte sum of the last completed frame
// Optional feature: define OV7670_SRC_CHECKSUM_EN to build the checksum
// accumulator; otherwise frameChecksum is tied to 0.
module ov7670_pattern_source
    import ov7670_src_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  patternSel,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frameDone,
    output logic [15:0] frameChecksum
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HALF     = PCLK_DIV / 2;
    localparam int CW       = $clog2(LINE_LEN);
    localparam int DW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int MAX_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_L    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LW       = $clog2(MAX_L + 1);

    // pclk divider; fallTick marks the clk edge on which pclk goes 1->0,
    // the only edge on which the bus and frame position advance.
    logic [DW-1:0] divCnt;
    logic          fallTick;

    assign fallTick = pclk && (divCnt == DW'(HALF - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
            pclk   <= 1'b0;
        end else if (divCnt == DW'(HALF - 1)) begin
            divCnt <= '0;
            pclk   <= ~pclk;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // Current frame position (what is on the bus now).
    frameState_e  state, nState;
    logic [LW-1:0] line, nLine, lastLine;
    logic [CW-1:0] col, nCol;
    logic [BW-1:0] barCnt, nBarCnt;
    logic [2:0]    barIdx, nBarIdx;
    patternKind_e  patLatch, genPattern;
    logic          frameStart, doneNow, nHref;
    logic [7:0]    nData;
    logic [15:0]   pixel;

    // Next position, i.e. what goes on the bus at the coming pclk fall.
    always_comb begin
        nState     = state;
        nLine      = line;
        nCol       = col;
        nBarCnt    = barCnt;
        nBarIdx    = barIdx;
        frameStart = 1'b0;
        lastLine   = '0;

        case (state)
            ST_VSYNC:  lastLine = LW'(VSYNC_LINES - 1);
            ST_VBACK:  lastLine = LW'(V_BACK - 1);
            ST_ACTIVE: lastLine = LW'(V_ACTIVE - 1);
            ST_VFRONT: lastLine = LW'(V_FRONT - 1);
            default:   lastLine = '0;
        endcase

        if (state == ST_IDLE) begin
            if (enable) begin
                nState     = ST_VSYNC;
                nLine      = '0;
                nCol       = '0;
                frameStart = 1'b1;
            end
        end else if (col == CW'(LINE_LEN - 1)) begin
            nCol = '0;
            if (line == lastLine) begin
                nLine = '0;
                case (state)
                    ST_VSYNC:  nState = ST_VBACK;
                    ST_VBACK:  nState = ST_ACTIVE;
                    ST_ACTIVE: nState = ST_VFRONT;
                    default: begin
                        if (enable) begin
                            nState     = ST_VSYNC;
                            frameStart = 1'b1;
                        end else begin
                            nState = ST_IDLE;
                        end
                    end
                endcase
            end else begin
                nLine = line + 1'b1;
            end
        end else begin
            nCol = col + 1'b1;
        end

        // Bar index steps every BAR_W pixels; a counter avoids dividing x.
        if (nCol == '0) begin
            nBarCnt = '0;
            nBarIdx = '0;
        end else if (!nCol[0] && (nCol < CW'(2 * H_ACTIVE))) begin
            if (barCnt == BW'(BAR_W - 1)) begin
                nBarCnt = '0;
                nBarIdx = barIdx + 3'd1;
            end else begin
                nBarCnt = barCnt + 1'b1;
            end
        end
    end

    // The pattern used for a new frame is taken straight from the port so
    // the first positions of the frame already see the fresh selection.
    assign genPattern = frameStart ? patternKind_e'(patternSel) : patLatch;

    ov7670_pattern_gen patternGen (
        .x       (8'(nCol >> 1)),
        .y       (8'(nLine)),
        .barIdx  (nBarIdx),
        .pattern (genPattern),
        .pixel   (pixel)
    );

    assign nHref   = (nState == ST_ACTIVE) && (nCol < CW'(2 * H_ACTIVE));
    assign nData   = !nHref ? 8'h00 : (nCol[0] ? pixel[7:0] : pixel[15:8]);
    // Last byte of the last active line is on the bus; the coming fall drops href.
    assign doneNow = (state == ST_ACTIVE) && (line == LW'(V_ACTIVE - 1)) &&
                     (col == CW'(2 * H_ACTIVE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            line     <= '0;
            col      <= '0;
            barCnt   <= '0;
            barIdx   <= '0;
            patLatch <= PAT_BARS;
            vsync    <= 1'b0;
            href     <= 1'b0;
            data     <= 8'h00;
        end else if (fallTick) begin
            state  <= nState;
            line   <= nLine;
            col    <= nCol;
            barCnt <= nBarCnt;
            barIdx <= nBarIdx;
            if (frameStart) patLatch <= patternKind_e'(patternSel);
            vsync  <= (nState == ST_VSYNC);
            href   <= nHref;
            data   <= nData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) frameDone <= 1'b0;
        else       frameDone <= fallTick && doneNow;
    end

`ifdef OV7670_SRC_CHECKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc           <= '0;
            frameChecksum <= '0;
        end else if (fallTick) begin
            if (frameStart)  acc <= '0;
            else if (nHref)  acc <= acc + {8'h00, nData};
            // acc already holds the final byte, added on the previous fall.
            if (doneNow) frameChecksum <= acc;
        end
    end
`else
    assign frameChecksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_pattern_source.sv
module tb_ov7670_pattern_source;

    localparam int VA = 4, HB = 4, VS = 2, VB = 1, VF = 1, PDIV = 2;
`ifdef OV7670_SRC_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] d;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] patternSel;
    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            if (nFails <= 40)
                $display("FAIL %s dut%0d t=%0t got %h want %h", name, g, $time, act, exp);
        end
    endtask

    // Reference pixel straight from the pattern definitions.
    function automatic logic [15:0] pixelOf(input int pat, input int x, input int y, input int ha);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (pat)
            0:       return bars[x * 8 / ha];
            1:       return {x[7:0], y[7:0]};
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int HA = (g == 0) ? 8 : 16;
        localparam int LL = 2 * HA + HB;
        localparam int FP = LL * (VS + VB + VA + VF);
        localparam int HALF = PDIV / 2;

        logic        pclk, vsync, href, frameDone;
        logic [7:0]  data;
        logic [15:0] frameChecksum;

        ov7670_pattern_source #(
            .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
            .V_BACK(VB), .V_FRONT(VF), .PCLK_DIV(PDIV)
        ) dut (
            .clk(clk), .reset(rst), .enable(enable), .patternSel(patternSel),
            .pclk(pclk), .vsync(vsync), .href(href), .data(data),
            .frameDone(frameDone), .frameChecksum(frameChecksum)
        );

        bus_t        q[$];
        int          cyc, off, pat;
        bit          inFrame, expDone, mActive;
        logic [15:0] sum, expChk;

        // Model: a frame is FP pclk periods starting at the first pclk fall
        // with enable high; everything inside is derived from the offset.
        always @(posedge clk or posedge rst) begin : model
            bus_t e;
            int line, col, y, x;
            logic [15:0] px;
            if (rst) begin
                cyc = 0; inFrame = 0; off = 0; expDone = 0; mActive = 0;
                sum = 0; expChk = 0;
                q.delete();
                q.push_back('0);
            end else begin
                e = '0;
                expDone = 0;
                cyc++;
                if (cyc % PDIV == 0) begin
                    if (inFrame) begin
                        off++;
                        if (off == FP) inFrame = 0;
                    end
                    if (!inFrame && enable) begin
                        inFrame = 1; off = 0; pat = int'(patternSel); sum = 0;
                    end
                    mActive = 0;
                    if (inFrame) begin
                        line = off / LL;
                        col  = off % LL;
                        y    = line - VS - VB;
                        e.vs = (line < VS);
                        mActive = (y >= 0) && (y < VA);
                        if (mActive && col < 2 * HA) begin
                            x    = col / 2;
                            px   = pixelOf(pat, x, y, HA);
                            e.hr = 1'b1;
                            e.d  = (col % 2 == 0) ? px[15:8] : px[7:0];
                            sum  = sum + 16'(e.d);
                        end
                        if (y == VA - 1 && col == 2 * HA) begin
                            expDone = 1;
                            expChk  = CHK ? sum : 16'h0000;
                        end
                    end
                    q.push_back(e);
                end
            end
        end

        // Bus monitor: every pclk rise must present the byte pushed at the
        // preceding fall.
        always @(posedge pclk) begin : busMon
            bus_t e;
            if (q.size() == 0) begin
                chk("bus_queue_empty", g, 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("vsync", g, 32'(vsync), 32'(e.vs));
                chk("href", g, 32'(href), 32'(e.hr));
                chk("data", g, 32'(data), 32'(e.d));
            end
        end

        always @(negedge clk) begin : cycMon
            chk("pclk", g, 32'(pclk), 32'((cyc / HALF) % 2));
            chk("frameDone", g, 32'(frameDone), 32'(expDone));
            chk("frameChecksum", g, 32'(frameChecksum), 32'(expChk));
        end

        always @(posedge rst) begin : rstMon
            #1;
            chk("rst_outputs", g, {12'h0, pclk, vsync, href, frameDone, data, 8'h00},
                32'h0);
            chk("rst_checksum", g, 32'(frameChecksum), 32'h0);
        end
    end

    task automatic waitActive();
        int n = 0;
        while (!inst[0].mActive && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_active", 0, 32'(inst[0].mActive), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        patternSel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed: solid, gradient, bars, checker, each for a couple of frames.
        enable = 1'b1;
        patternSel = 2'd3; repeat (700) @(negedge clk);
        patternSel = 2'd1; repeat (700) @(negedge clk);
        patternSel = 2'd0; repeat (700) @(negedge clk);
        patternSel = 2'd2; repeat (700) @(negedge clk);

        // Random enable gaps and mid-frame pattern changes.
        for (int i = 0; i < 16; i++) begin
            patternSel = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(20, 500)) @(negedge clk);
        end

        // Drop enable during active video: frame completes, then idle.
        enable = 1'b1;
        patternSel = 2'($urandom_range(0, 3));
        repeat (400) @(negedge clk);
        waitActive();
        enable = 1'b0;
        repeat (1500) @(negedge clk);

        // Reset pulse in the middle of active video, then a clean restart.
        enable = 1'b1;
        patternSel = 2'd1;
        repeat (20) @(negedge clk);
        waitActive();
        repeat ($urandom_range(0, 40)) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (1300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
